bit_fifo_arbiter: RTL and testbench
===================================

# bit_fifo_arbiter

Round-robin arbiter and sequencer that shares one `bit_fifo` width converter (IWIDTH-bit in, OWIDTH-bit out) between NREQ requesters. It grants one requester a burst, forwards its words into `bit_fifo`, and zero-pads the tail so every output word holds bits from exactly one requester. It tags each output word with the owning requester's index. It sits between the requester-side transmit logic and the shared `bit_fifo` instance, and drives that instance's `en` and `in_valid` inputs.

## Interface
- NREQ, 2: number of requesters (≥2)
- IWIDTH, 3: requester word width; matches `bit_fifo` IWIDTH
- OWIDTH, 7: output word width; matches `bit_fifo` OWIDTH
- MAX_BURST, 8: maximum words accepted per grant
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  NREQ*IWIDTH  requester words; requester i occupies bits [i*IWIDTH +: IWIDTH]
- in_valid  in  NREQ  word valid per requester; also serves as the request
- in_last  in  NREQ  final word of requester's packet
- in_ready  out  NREQ  accept strobe per requester
- fifo_en, fifo_in_valid  out  1 each  to `bit_fifo` en / in_valid
- fifo_in  out  IWIDTH  to `bit_fifo` in
- fifo_out  in  OWIDTH  from `bit_fifo` out
- fifo_out_valid  in  1  from `bit_fifo` out_valid
- out_word  out  OWIDTH  fifo_out passthrough
- out_valid  out  1  qualified output strobe
- out_src  out  $clog2(NREQ)  owner of out_word

## Operation
- **States:** IDLE, GRANT, PAD, DRAIN.
- **IDLE:**
  - If any in_valid is high, choose owner = first requesting index at or after rr_ptr, wrapping.
  - Register owner, clear word_cnt, go to GRANT.
- **GRANT:**
  - in_ready[owner] = 1; all other in_ready bits are 0.
  - accept = in_valid[owner] & in_ready[owner].
  - On accept: fifo_en = fifo_in_valid = 1, fifo_in = owner's word, word_cnt++, and acc is updated.
  - acc holds accumulated bits mod OWIDTH: acc_next = (acc+IWIDTH) mod OWIDTH.
  - Per accept, outstanding += floor((acc+IWIDTH)/OWIDTH).
  - The burst ends on an accept with in_last[owner], or on the accept with word_cnt == MAX_BURST-1.
  - At burst end: if acc_next == 0, go to DRAIN; otherwise go to PAD.
  - Without accept: fifo_en = fifo_in_valid = 0 and state is held.
- **PAD:**
  - Each cycle: fifo_en = fifo_in_valid = 1, fifo_in = 0, with the same acc/outstanding updates as an accept.
  - Go to DRAIN on the cycle acc_next == 0.
  - Pad count never exceeds OWIDTH-1.
- **DRAIN:**
  - No input to `bit_fifo`.
  - Go to IDLE when outstanding reaches 0, counting a decrement in the same cycle.
  - rr_ptr = (owner+1) mod NREQ.
- **Output path:**
  - out_valid = fifo_out_valid & (outstanding != 0).
  - outstanding decrements on out_valid; simultaneous increment and decrement both apply.
  - out_src = owner, held through DRAIN.
  - fifo_out_valid while outstanding == 0 is dropped.
- **fifo_en rule:** fifo_en is never high while fifo_in_valid is low.
- **Width rules:**
  - acc width is $clog2(OWIDTH).
  - outstanding is sized for ceil((MAX_BURST+OWIDTH)*IWIDTH/OWIDTH).

## Timing
- **Reset values:** state = IDLE, rr_ptr = 0, owner = 0, acc = 0, outstanding = 0, word_cnt = 0. All outputs are 0, including in_ready, fifo_en, fifo_in_valid, fifo_in, out_valid and out_src.
- **Reset is asynchronous:** outputs take reset values immediately on the rst_n falling edge, without waiting for a clock.
- **Grant latency:** one cycle from request in IDLE to in_ready high.
- **Burst end / PAD:** PAD starts the cycle after the last accept.
- **Bubble between bursts:** at least one IDLE cycle separates consecutive bursts.
- **in_ready is combinational from state:** it does not depend on in_valid.
- **Reset mid-burst:**
  - `bit_fifo` has no reset, so partial bits left in it are not cleared.
  - Complete stale words are suppressed because outstanding = 0.
  - The upstream system guarantees reset only when the converter holds no partial word.

## Configuration
- **BIT_FIFO_ARB_PRIORITY_EN:**
  - Defined: IDLE selects the lowest requesting index (fixed priority); rr_ptr is unused.
  - Undefined: round-robin selection as described under Operation.

## Test plan
- **Reset:** drive rst_n low mid-cycle with in_valid = 2'b11 -> all outputs 0 immediately; no in_ready until one cycle after the first clk edge with rst_n high.
- **Exact fill:** req0 sends 7 words of 3'b101, in_last on the 7th -> no PAD cycles, 3 out_valid pulses with out_src = 0, return to IDLE.
- **Pad:** req0 sends 2 words, in_last on the 2nd -> 5 PAD cycles with fifo_in = 0, then 3 output words with out_src = 0.
- **Round robin (macro undefined):** both requesters valid continuously, no in_last -> grants 0,1,0,1. Each burst is 8 words plus 6 pads, producing 6 output words. out_src matches the grant for each burst.
- **Stall:** req1 drops in_valid for 3 cycles mid-burst -> fifo_in_valid = 0 for those cycles; acc, word_cnt and state are unchanged; the burst resumes.
- **Priority (BIT_FIFO_ARB_PRIORITY_EN defined):** both requesters valid continuously -> every grant goes to requester 0.

Source files
------------

// File: rtl/bit_fifo_arbiter.sv
// bit_fifo_arbiter: round-robin burst sequencer sharing one bit_fifo; define BIT_FIFO_ARB_PRIORITY_EN for fixed priority
module bit_fifo_arbiter #(
  parameter int NREQ      = 2,
  parameter int IWIDTH    = 3,
  parameter int OWIDTH    = 7,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ*IWIDTH-1:0]    in_data,
  input  logic [NREQ-1:0]           in_valid,
  input  logic [NREQ-1:0]           in_last,
  output logic [NREQ-1:0]           in_ready,
  output logic                      fifo_en,
  output logic                      fifo_in_valid,
  output logic [IWIDTH-1:0]         fifo_in,
  input  logic [OWIDTH-1:0]         fifo_out,
  input  logic                      fifo_out_valid,
  output logic [OWIDTH-1:0]         out_word,
  output logic                      out_valid,
  output logic [$clog2(NREQ)-1:0]   out_src
);
  localparam int SW   = $clog2(NREQ);
  localparam int AW   = $clog2(OWIDTH);
  localparam int CW   = $clog2(MAX_BURST + 1);
  localparam int TW   = $clog2(OWIDTH + IWIDTH);
  localparam int OMAX = ((MAX_BURST + OWIDTH) * IWIDTH + OWIDTH - 1) / OWIDTH;
  localparam int OW   = $clog2(OMAX + 1);

  typedef enum logic [1:0] {IDLE, GRANT, PAD, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]   owner_q, owner_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;

  logic [TW-1:0]   sum;
  logic [AW-1:0]   acc_next;
  logic [OW-1:0]   inc;
  logic            accept;
  logic            push;
  logic            last_word;
  logic [SW-1:0]   start;

  // First requester at or after start, wrapping; start = 0 gives fixed priority
  function automatic logic [SW-1:0] pick_owner(input logic [NREQ-1:0] v, input logic [SW-1:0] s);
    logic [SW-1:0] p;
    p = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int j;
      j = int'(s) + i;
      if (j >= NREQ) j = j - NREQ;
      if (v[j]) p = SW'(j);
    end
    return p;
  endfunction

  // Datapath: bit accounting, handshakes and bit_fifo drive
  always_comb begin
`ifdef BIT_FIFO_ARB_PRIORITY_EN
    start = '0;
`else
    start = rr_ptr_q;
`endif
    sum           = TW'(acc_q) + TW'(IWIDTH);
    acc_next      = AW'(sum % TW'(OWIDTH));
    inc           = OW'(sum / TW'(OWIDTH));
    accept        = (state_q == GRANT) && in_valid[owner_q];
    push          = accept || (state_q == PAD);
    last_word     = in_last[owner_q] || (word_cnt_q == CW'(MAX_BURST - 1));
    out_valid     = fifo_out_valid && (out_cnt_q != '0);
    out_cnt_d     = out_cnt_q + (push ? inc : '0) - OW'(out_valid);
    in_ready      = (state_q == GRANT) ? NREQ'(1) << owner_q : '0;
    fifo_en       = push;
    fifo_in_valid = push;
    fifo_in       = accept ? in_data[owner_q*IWIDTH +: IWIDTH] : '0;
    out_word      = fifo_out;
    out_src       = owner_q;
  end

  // Next-state logic for the grant/pad/drain sequence
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    acc_d      = push ? acc_next : acc_q;
    word_cnt_d = accept ? word_cnt_q + CW'(1) : word_cnt_q;
    case (state_q)
      IDLE: if (|in_valid) begin
        owner_d    = pick_owner(in_valid, start);
        word_cnt_d = '0;
        state_d    = GRANT;
      end
      GRANT: if (accept && last_word) state_d = (acc_next == '0) ? DRAIN : PAD;
      PAD: if (acc_next == '0) state_d = DRAIN;
      DRAIN: begin
        rr_ptr_d = (owner_q == SW'(NREQ - 1)) ? '0 : owner_q + SW'(1);
        if (out_cnt_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      acc_q      <= '0;
      out_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      acc_q      <= acc_d;
      out_cnt_q  <= out_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end
endmodule

// File: tb/tb_bit_fifo_arbiter.sv
// tb_bit_fifo_arbiter: directed bench with a behavioural bit_fifo model
module tb_bit_fifo_arbiter;
  localparam int IW  = 3;
  localparam int OWD = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] in_data;
  logic [1:0] in_valid, in_last, in_ready;
  logic       fifo_en, fifo_in_valid;
  logic [2:0] fifo_in;
  logic [6:0] fifo_out;
  logic       fifo_out_valid;
  logic [6:0] out_word;
  logic       out_valid;
  logic [0:0] out_src;

  logic [15:0] sreg;
  int          bits;
  logic        fo_valid;
  logic [6:0]  fo_word;
  logic        inject;

  int n_cmp, n_err;
  int n_pad = 0, n_pad_bad = 0, n_en_bad = 0, n_out = 0, n_acc = 0;
  logic [0:0] src_q[$];
  logic [6:0] word_q[$];

  always #5 clk = ~clk;

  assign fifo_out       = fo_word;
  assign fifo_out_valid = fo_valid | inject;

  bit_fifo_arbiter dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .fifo_en(fifo_en), .fifo_in_valid(fifo_in_valid), .fifo_in(fifo_in),
    .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid), .out_word(out_word),
    .out_valid(out_valid), .out_src(out_src)
  );

  // Width converter model: MSB-first bit stream, one registered output word per completed OWD bits
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0; bits <= 0; fo_valid <= 1'b0; fo_word <= '0;
    end else begin
      fo_valid <= 1'b0;
      if (fifo_en && fifo_in_valid) begin
        sreg <= {sreg[12:0], fifo_in};
        if (bits + IW >= OWD) begin
          fo_valid <= 1'b1;
          fo_word  <= 7'({sreg[12:0], fifo_in} >> (bits + IW - OWD));
          bits     <= bits + IW - OWD;
        end else bits <= bits + IW;
      end
    end
  end

  // Activity monitor sampled mid-cycle, after the bench has driven inputs
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (fifo_en !== fifo_in_valid) n_en_bad++;
      if (fifo_in_valid && in_ready == 2'b00) begin
        n_pad++;
        if (fifo_in !== 3'b000) n_pad_bad++;
      end
      if (fifo_in_valid && in_ready != 2'b00) n_acc++;
      if (out_valid) begin
        src_q.push_back(out_src);
        word_q.push_back(out_word);
        n_out++;
      end
    end
  end

  task automatic send(input int r, input int n, input logic last, input logic [2:0] d);
    int idx = 0;
    int guard = 0;
    logic rdy;
    in_data[r*3 +: 3] = d;
    in_last[r] = last && (n == 1);
    in_valid[r] = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready[r] !== 1'b1) begin n_err++; $display("FAIL grant_latency: got %b, want 1", in_ready[r]); end
    while (idx < n && guard < 100) begin
      rdy = in_ready[r];
      in_last[r] = last && (idx == n - 1);
      @(negedge clk);
      if (rdy) idx++;
      guard++;
    end
    in_valid[r] = 1'b0;
    in_last[r] = 1'b0;
    n_cmp++; if (idx != n) begin n_err++; $display("FAIL send_accepts: got %0d, want %0d", idx, n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 2'b11; in_last = 2'b00; in_data = 6'b111111; inject = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 2'b00) begin n_err++; $display("FAIL reset_held_ready: got %b, want 00", in_ready); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 2'b00) begin n_err++; $display("FAIL ready_before_edge: got %b, want 00", in_ready); end
    @(negedge clk);
    n_cmp++; if (in_ready !== 2'b01) begin n_err++; $display("FAIL first_grant: got %b, want 01", in_ready); end
    n_cmp++; if (fifo_in !== 3'b111 || fifo_in_valid !== 1'b1) begin n_err++; $display("FAIL first_accept: got %b/%b, want 111/1", fifo_in, fifo_in_valid); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 2'b00) begin n_err++; $display("FAIL async_in_ready: got %b, want 00", in_ready); end
    n_cmp++; if (fifo_en !== 1'b0) begin n_err++; $display("FAIL async_fifo_en: got %b, want 0", fifo_en); end
    n_cmp++; if (fifo_in_valid !== 1'b0) begin n_err++; $display("FAIL async_fifo_in_valid: got %b, want 0", fifo_in_valid); end
    n_cmp++; if (fifo_in !== 3'b000) begin n_err++; $display("FAIL async_fifo_in: got %b, want 000", fifo_in); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_out_valid: got %b, want 0", out_valid); end
    n_cmp++; if (out_src !== 1'b0) begin n_err++; $display("FAIL async_out_src: got %b, want 0", out_src); end
    in_valid = 2'b00; in_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exact_fill();
    logic [6:0] exp_w [3] = '{7'b1011011, 7'b0110110, 7'b1101101};
    int p0 = n_pad, o0 = n_out, a0 = n_acc, qb = src_q.size();
    send(0, 7, 1'b1, 3'b101);
    repeat (12) @(negedge clk);
    n_cmp++; if (n_acc - a0 != 7) begin n_err++; $display("FAIL fill_accepts: got %0d, want 7", n_acc - a0); end
    n_cmp++; if (n_pad - p0 != 0) begin n_err++; $display("FAIL fill_pads: got %0d, want 0", n_pad - p0); end
    n_cmp++; if (n_out - o0 != 3) begin n_err++; $display("FAIL fill_outs: got %0d, want 3", n_out - o0); end
    for (int k = 0; k < 3 && qb + k < src_q.size(); k++) begin
      n_cmp++; if (src_q[qb+k] !== 1'b0) begin n_err++; $display("FAIL fill_src[%0d]: got %b, want 0", k, src_q[qb+k]); end
      n_cmp++; if (word_q[qb+k] !== exp_w[k]) begin n_err++; $display("FAIL fill_word[%0d]: got %b, want %b", k, word_q[qb+k], exp_w[k]); end
    end
  endtask

  task automatic test_pad();
    int p0 = n_pad, o0 = n_out, a0 = n_acc, qb = src_q.size();
    send(0, 2, 1'b1, 3'b011);
    repeat (12) @(negedge clk);
    n_cmp++; if (n_acc - a0 != 2) begin n_err++; $display("FAIL pad_accepts: got %0d, want 2", n_acc - a0); end
    n_cmp++; if (n_pad - p0 != 5) begin n_err++; $display("FAIL pad_cycles: got %0d, want 5", n_pad - p0); end
    n_cmp++; if (n_out - o0 != 3) begin n_err++; $display("FAIL pad_outs: got %0d, want 3", n_out - o0); end
    for (int k = 0; k < 3 && qb + k < src_q.size(); k++) begin
      n_cmp++; if (src_q[qb+k] !== 1'b0) begin n_err++; $display("FAIL pad_src[%0d]: got %b, want 0", k, src_q[qb+k]); end
    end
  endtask

  task automatic test_stall();
    int p0 = n_pad, o0 = n_out, a0 = n_acc, qb = src_q.size();
    int guard = 0;
    in_data[5:3] = 3'b110; in_last = 2'b00; in_valid = 2'b10;
    @(negedge clk);
    n_cmp++; if (in_ready !== 2'b10) begin n_err++; $display("FAIL stall_grant: got %b, want 10", in_ready); end
    repeat (3) @(negedge clk);
    in_valid[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (fifo_in_valid !== 1'b0) begin n_err++; $display("FAIL stall_fifo_in_valid[%0d]: got %b, want 0", k, fifo_in_valid); end
      n_cmp++; if (in_ready !== 2'b10) begin n_err++; $display("FAIL stall_hold[%0d]: got %b, want 10", k, in_ready); end
      @(negedge clk);
    end
    in_valid[1] = 1'b1;
    while (in_ready[1] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 2'b00;
    repeat (12) @(negedge clk);
    n_cmp++; if (n_acc - a0 != 8) begin n_err++; $display("FAIL stall_accepts: got %0d, want 8", n_acc - a0); end
    n_cmp++; if (n_pad - p0 != 6) begin n_err++; $display("FAIL stall_pads: got %0d, want 6", n_pad - p0); end
    n_cmp++; if (n_out - o0 != 6) begin n_err++; $display("FAIL stall_outs: got %0d, want 6", n_out - o0); end
    for (int k = 0; k < 6 && qb + k < src_q.size(); k++) begin
      n_cmp++; if (src_q[qb+k] !== 1'b1) begin n_err++; $display("FAIL stall_src[%0d]: got %b, want 1", k, src_q[qb+k]); end
    end
  endtask

  task automatic test_round_robin();
    logic [0:0] g[$];
    logic prev = 1'b0;
    logic [0:0] e;
    int guard = 0;
    int p0 = n_pad, qb = src_q.size();
    in_data = 6'b010001; in_last = 2'b00; in_valid = 2'b11;
    while (g.size() < 5 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (in_ready != 2'b00 && !prev) g.push_back(in_ready[1]);
      prev = (in_ready != 2'b00);
    end
    in_valid = 2'b01; in_last = 2'b01;
    @(negedge clk);
    in_valid = 2'b00; in_last = 2'b00;
    repeat (12) @(negedge clk);
    n_cmp++; if (g.size() != 5) begin n_err++; $display("FAIL rr_grant_count: got %0d, want 5", g.size()); end
    for (int k = 0; k < 4 && k < g.size(); k++) begin
      e = 1'(k % 2);
`ifdef BIT_FIFO_ARB_PRIORITY_EN
      e = 1'b0;
`endif
      n_cmp++; if (g[k] !== e) begin n_err++; $display("FAIL rr_grant[%0d]: got %b, want %b", k, g[k], e); end
    end
    n_cmp++; if (src_q.size() - qb != 27) begin n_err++; $display("FAIL rr_out_words: got %0d, want 27", src_q.size() - qb); end
    n_cmp++; if (n_pad - p0 != 30) begin n_err++; $display("FAIL rr_pads: got %0d, want 30", n_pad - p0); end
    for (int k = 0; k < 24 && qb + k < src_q.size(); k++) begin
      e = 1'((k / 6) % 2);
`ifdef BIT_FIFO_ARB_PRIORITY_EN
      e = 1'b0;
`endif
      n_cmp++; if (src_q[qb+k] !== e) begin n_err++; $display("FAIL rr_src[%0d]: got %b, want %b", k, src_q[qb+k], e); end
    end
  endtask

  task automatic test_drop();
    @(negedge clk);
    inject = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drop_idle_valid: got %b, want 0", out_valid); end
    @(negedge clk);
    inject = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_data[5:3] = 3'b111; in_valid = 2'b10;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_src !== 1'b1) begin n_err++; $display("FAIL mid_src_before: got %b, want 1", out_src); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_src !== 1'b0) begin n_err++; $display("FAIL mid_src_after: got %b, want 0", out_src); end
    n_cmp++; if (in_ready !== 2'b00 || fifo_in_valid !== 1'b0) begin n_err++; $display("FAIL mid_handshake: got %b/%b, want 00/0", in_ready, fifo_in_valid); end
    in_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    in_valid = 2'b00; in_last = 2'b00; in_data = '0; inject = 1'b0;
    test_reset();
    test_exact_fill();
    test_pad();
    test_stall();
    test_round_robin();
    test_drop();
    test_reset_mid();
    n_cmp++; if (n_en_bad != 0) begin n_err++; $display("FAIL en_follows_valid: got %0d bad cycles, want 0", n_en_bad); end
    n_cmp++; if (n_pad_bad != 0) begin n_err++; $display("FAIL pad_zero_data: got %0d bad pads, want 0", n_pad_bad); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
